// File: rtl/svc_rv_mul_seq.sv
// svc_rv_mul_seq: sequential Zmmul multiplier for the RV execute stage.
// Computes MUL / MULH / MULHSU / MULHU with a shift-add datapath and
// returns the selected XLEN-bit half of the 2*XLEN product.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         EX holds a Zmmul op (level, held while stalled)
//   flush         kill any in-flight op (same flush that clears ID/EX)
//   funct3        000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; bit 2 set = no op
//   rs1_data      multiplicand (signed for MULH/MULHSU)
//   rs2_data      multiplier (signed for MULH)
//   busy          combinational stall request to ID/EX and upstream
//   result_valid  registered one-cycle pulse with the final result
//   result        registered result, held until the next completed op
//
// Build option: define SVC_RV_MUL_RADIX4_EN to retire two multiplier bits
// per cycle (XLEN/2 iterations) instead of one (XLEN iterations).

module svc_rv_mul_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int unsigned PW    = 2 * XLEN;
`ifdef SVC_RV_MUL_RADIX4_EN
    localparam int unsigned ITERS = XLEN / 2;
    localparam int unsigned SUM_W = XLEN + 2;
`else
    localparam int unsigned ITERS = XLEN;
    localparam int unsigned SUM_W = XLEN + 1;
`endif
    localparam int unsigned CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Upper half accumulates partial sums; lower half holds the multiplier
    // bits not yet retired, replaced by product bits as they shift in.
    logic [PW-1:0]     prod_q, prod_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic              neg_q, neg_d;
    logic              hi_q, hi_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              result_valid_q, result_valid_d;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [SUM_W-1:0]  addend, sum;
    logic [PW-1:0]     prod_step, prod_fix;

    // Operand signedness and magnitudes; -2^(XLEN-1) maps to unsigned 2^(XLEN-1).
    always_comb begin
        a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
        b_signed = (funct3[1:0] == 2'b01);
        a_neg    = a_signed && rs1_data[XLEN-1];
        b_neg    = b_signed && rs2_data[XLEN-1];
        a_mag    = a_neg ? ((~rs1_data) + XLEN'(1)) : rs1_data;
        b_mag    = b_neg ? ((~rs2_data) + XLEN'(1)) : rs2_data;
    end

    // One shift-add step on the product register.
    always_comb begin
`ifdef SVC_RV_MUL_RADIX4_EN
        case (prod_q[1:0])
            2'd0:    addend = '0;
            2'd1:    addend = SUM_W'(mcand_q);
            2'd2:    addend = SUM_W'({mcand_q, 1'b0});
            default: addend = SUM_W'(mcand_q) + SUM_W'({mcand_q, 1'b0});
        endcase
        sum       = SUM_W'(prod_q[PW-1:XLEN]) + addend;
        prod_step = {sum, prod_q[XLEN-1:2]};
`else
        addend    = prod_q[0] ? SUM_W'(mcand_q) : '0;
        sum       = SUM_W'(prod_q[PW-1:XLEN]) + addend;
        prod_step = {sum, prod_q[XLEN-1:1]};
`endif
        prod_fix  = neg_q ? ((~prod_step) + PW'(1)) : prod_step;
    end

    // Next-state and output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        prod_d         = prod_q;
        mcand_d        = mcand_q;
        neg_d          = neg_q;
        hi_d           = hi_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        accept = (state_q == S_IDLE) && start && !funct3[2] && !flush;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d = a_mag;
                    prod_d  = {XLEN'(0), b_mag};
                    neg_d   = a_neg ^ b_neg;
                    hi_d    = (funct3[1:0] != 2'b00);
                    cnt_d   = CNT_W'(ITERS - 1);
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                prod_d = prod_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d          = '0;
                    result_d       = hi_q ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0];
                    result_valid_d = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Flush kills the op without disturbing the last delivered result.
        if (flush) begin
            state_d        = S_IDLE;
            result_d       = result_q;
            result_valid_d = 1'b0;
        end

        busy = !flush && (accept || (state_q == S_BUSY));
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            prod_q         <= '0;
            mcand_q        <= '0;
            neg_q          <= 1'b0;
            hi_q           <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prod_q         <= prod_d;
            mcand_q        <= mcand_d;
            neg_q          <= neg_d;
            hi_q           <= hi_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_svc_rv_mul_seq.sv
// Testbench for svc_rv_mul_seq: directed multiplies with a scoreboard queue
// of expected results/cycles, popped by an independent result monitor.

module tb_svc_rv_mul_seq;

`ifdef SVC_RV_MUL_RADIX4_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    svc_rv_mul_seq #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .flush        (flush),
        .funct3       (funct3),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every result_valid must match the oldest pending expectation.
    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_valid: result_valid=1 result=%h at cycle %0d, required no pending op",
                         result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                if (result !== e.res || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: result=%h at cycle %0d, required %h at cycle %0d",
                             e.name, result, cyc, e.res, e.cyc);
                end
            end
        end
    end

    // Issue one op at the next cycle T and hold start through DONE (T+N+1).
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int t;
        @(posedge clk); #1;
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
        t = cyc;
        sb.push_back('{exp, t + N + 1, nm});
        for (int i = 0; i <= N + 1; i++) begin
            @(negedge clk);
            chk({nm, "_busy"}, 32'(busy), 32'(i <= N));
        end
        last_res = exp;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Start an op, kill it with flush or rst 'at' cycles after accept.
    task automatic run_kill(input logic [31:0] a, input logic [31:0] b, input int at,
                            input bit use_rst, input logic [31:0] exp_after, input string nm);
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b011; rs1_data = a; rs2_data = b;
        for (int i = 0; i < at; i++) begin
            @(negedge clk);
            chk({nm, "_busy_pre"}, 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(negedge clk);
        if (!use_rst) chk({nm, "_busy_flush"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        chk({nm, "_result_after"}, result, exp_after);
        repeat (N + 4) @(negedge clk);
        chk({nm, "_result_held"}, result, exp_after);
        chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
        last_res = exp_after;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_valid", 32'(result_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Back-to-back with start held high: second op accepted at T+N+2.
        run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1_m1");
        run_op(3'b000, 32'd3,         32'd5,         32'h0000_000F, "mul_3_5");
        idle(2);
        chk("result_held_idle", result, 32'h0000_000F);

        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        idle(1);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1");
        idle(1);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1_max");
        idle(1);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");
        idle(1);
        run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
        idle(1);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "mulhsu_min_max");
        idle(1);
        run_op(3'b001, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "mulh_min_1");
        idle(1);
        run_op(3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, "mulhu_carry");
        idle(1);
        run_op(3'b000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, "mul_zero");
        idle(1);
        run_op(3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, "mul_wrap");
        idle(1);

        // Flush mid-op: result keeps the previous value.
        run_kill(32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1'b0, last_res, "flush_t10");

        // Flush and accept in the same cycle: flush wins.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5;
        @(negedge clk);
        chk("flush_accept_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_accept_after", 32'(busy), 32'd0);
        repeat (N + 4) @(negedge clk);
        chk("flush_accept_result", result, last_res);

        // funct3[2] set: never accepted.
        @(posedge clk); #1;
        start = 1'b1; funct3 = 3'b100; rs1_data = 32'd9; rs2_data = 32'd9;
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            chk("f3_100_busy", 32'(busy), 32'd0);
        end
        idle(1);

        // Make result nonzero, then reset mid-op.
        run_op(3'b000, 32'd6, 32'd7, 32'h0000_002A, "mul_6_7");
        idle(1);
        run_kill(32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b1, 32'h0, "rst_t5");

        // Recovery after reset.
        run_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "mulhu_after_rst");
        idle(4);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
